forwarding_ctrl: RTL and testbench

FORWARDING_CTRL -- requirements
Module: forwarding_ctrl

---
 rtl/forwarding_ctrl.sv | 99 +++++++++
 tb/tb_forwarding_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/forwarding_ctrl.sv
// forwarding_ctrl: EX-aligned operand forwarding select and load-use stall for an in-order pipeline
// Ports: clk, arst (async, active-high), enable (advance), flush (kill instr entering EX),
//        id_src/id_src_valid/id_rd/id_reg_write/id_mem_read (ID instruction),
//        stall (combinational load-use), fwd_sel (per-port select: 0 = regfile, k = stage k),
//        stall_cnt/fwd_cnt (saturating perf counters, built only with FWD_PERF_CNT_EN, else 0).
module forwarding_ctrl #(
    parameter int N_SRC = 2,
    parameter int DEPTH = 2,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16,
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [N_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [N_SRC-1:0]            id_src_valid,
    input  logic [REG_ADDR_W-1:0]       id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_mem_read,
    output logic                        stall,
    output logic [N_SRC*SEL_W-1:0]      fwd_sel,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            fwd_cnt
);
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wr;
    logic                  ex_ld;
    logic [REG_ADDR_W-1:0] st_rd [DEPTH];
    logic                  st_wr [DEPTH];
    logic [N_SRC*SEL_W-1:0] sel_nxt;
    logic                  ex_hit;
    logic                  kill;

    function automatic logic hit(input logic [REG_ADDR_W-1:0] rd, input logic wr,
                                 input logic [REG_ADDR_W-1:0] s, input logic v);
        return v && wr && rd != '0 && rd == s;
    endfunction

    // Stages are scanned oldest-first so the youngest match overwrites; the last stage never feeds.
    always_comb begin
        sel_nxt = '0;
        ex_hit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = DEPTH - 1; j >= 1; j--)
                if (hit(st_rd[j-1], st_wr[j-1], id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_valid[i]))
                    sel_nxt[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
            if (hit(ex_rd, ex_wr, id_src[i*REG_ADDR_W +: REG_ADDR_W], id_src_valid[i])) begin
                sel_nxt[i*SEL_W +: SEL_W] = SEL_W'(1);
                ex_hit = 1'b1;
            end
        end
    end

    assign stall = ex_ld & ex_hit & ~flush;
    assign kill = stall | flush;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ex_rd <= '0;
            ex_wr <= 1'b0;
            ex_ld <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                st_rd[k] <= '0;
                st_wr[k] <= 1'b0;
            end
            fwd_sel <= '0;
        end else if (enable) begin
            st_rd[0] <= ex_rd;
            st_wr[0] <= ex_wr;
            for (int k = 1; k < DEPTH; k++) begin
                st_rd[k] <= st_rd[k-1];
                st_wr[k] <= st_wr[k-1];
            end
            ex_rd <= kill ? '0 : id_rd;
            ex_wr <= id_reg_write & ~kill;
            ex_ld <= id_mem_read & ~kill;
            fwd_sel <= kill ? '0 : sel_nxt;
        end
    end

`ifdef FWD_PERF_CNT_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            stall_cnt <= '0;
            fwd_cnt <= '0;
        end else if (enable) begin
            if (stall && ~&stall_cnt)
                stall_cnt <= stall_cnt + 1'b1;
            if (!kill && |sel_nxt && ~&fwd_cnt)
                fwd_cnt <= fwd_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
    assign fwd_cnt = '0;
`endif
endmodule

// File: tb/tb_forwarding_ctrl.sv
// tb_forwarding_ctrl: directed checks of forwarding selects, load-use stall, flush, freeze and async reset
module tb_forwarding_ctrl;
`ifdef FWD_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif
    logic        clk = 0;
    logic        arst = 0;
    logic        enable = 1;
    logic        flush = 0;
    logic [9:0]  id_src = '0;
    logic [1:0]  id_src_valid = '0;
    logic [4:0]  id_rd = '0;
    logic        id_reg_write = 0;
    logic        id_mem_read = 0;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt;
    logic [15:0] fwd_cnt;
    int          errors = 0;
    int          checks = 0;

    forwarding_ctrl dut (
        .clk(clk), .arst(arst), .enable(enable), .flush(flush),
        .id_src(id_src), .id_src_valid(id_src_valid), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rd, input bit wr, input bit ld,
                         input int s0, input bit v0, input int s1, input bit v1);
        id_rd = 5'(rd);
        id_reg_write = wr;
        id_mem_read = ld;
        id_src = {5'(s1), 5'(s0)};
        id_src_valid = {v1, v0};
        #1;
    endtask

    initial begin
        #1 arst = 1;
        #1;
        check("reset_sel", fwd_sel, 0);
        check("reset_stall", stall, 0);
        check("reset_scnt", stall_cnt, 0);
        check("reset_fcnt", fwd_cnt, 0);
        step();
        arst = 0;
        drive(3, 1, 0, 1, 1, 2, 1);
        step();
        drive(8, 1, 0, 3, 1, 4, 1);
        check("alu_stall", stall, 0);
        step();
        check("alu_fwd", fwd_sel, 1);
        drive(5, 1, 0, 0, 0, 0, 0);
        step();
        drive(5, 1, 0, 0, 0, 0, 0);
        step();
        drive(9, 1, 0, 5, 1, 0, 0);
        check("dbl_stall", stall, 0);
        step();
        check("dbl_youngest", fwd_sel, 1);
        drive(10, 1, 0, 0, 0, 5, 1);
        step();
        check("stage2_p1", fwd_sel, 8);
        drive(0, 0, 0, 5, 1, 0, 0);
        step();
        check("last_stage_unused", fwd_sel, 0);
        drive(4, 1, 1, 0, 0, 0, 0);
        step();
        drive(6, 1, 0, 4, 1, 7, 1);
        check("lu_stall", stall, 1);
        step();
        check("lu_bubble_stall", stall, 0);
        check("lu_bubble_sel", fwd_sel, 0);
        step();
        check("lu_reissue", fwd_sel, 2);
        check("lu_scnt", stall_cnt, PERF);
        enable = 0;
        drive(0, 0, 0, 6, 1, 0, 0);
        step();
        check("freeze_sel", fwd_sel, 2);
        check("freeze_stall", stall, 0);
        check("freeze_scnt", stall_cnt, PERF);
        enable = 1;
        step();
        check("resume_sel", fwd_sel, 1);
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        drive(7, 0, 0, 0, 1, 0, 1);
        check("r0_stall", stall, 0);
        step();
        check("r0_sel", fwd_sel, 0);
        drive(0, 1, 1, 7, 1, 0, 0);
        step();
        check("nowr_sel", fwd_sel, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("r0_load_stall", stall, 0);
        step();
        check("r0_load_sel", fwd_sel, 0);
        drive(4, 1, 1, 0, 0, 0, 0);
        step();
        flush = 1;
        drive(11, 1, 0, 4, 1, 0, 0);
        check("flush_stall", stall, 0);
        step();
        check("flush_sel", fwd_sel, 0);
        check("flush_scnt", stall_cnt, PERF);
        flush = 0;
        drive(0, 0, 0, 11, 1, 4, 1);
        check("flush_bubble_stall", stall, 0);
        step();
        check("flush_bubble_sel", fwd_sel, 8);
        drive(12, 1, 0, 0, 0, 0, 0);
        step();
        drive(4, 1, 1, 12, 1, 0, 0);
        step();
        check("pre_rst_sel", fwd_sel, 1);
        drive(6, 1, 0, 4, 1, 0, 0);
        check("pre_rst_stall", stall, 1);
        check("pre_rst_scnt", stall_cnt, PERF);
        check("pre_rst_fcnt", fwd_cnt, PERF * 7);
        #2 arst = 1;
        #1;
        check("arst_sel", fwd_sel, 0);
        check("arst_stall", stall, 0);
        check("arst_scnt", stall_cnt, 0);
        check("arst_fcnt", fwd_cnt, 0);
        #1 arst = 0;
        #1;
        check("post_rst_stall", stall, 0);
        step();
        check("post_rst_sel", fwd_sel, 0);
        check("post_rst_scnt", stall_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
